// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forward selects and FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } hz_state_e;

  localparam int HZ_REG_ADDR_W_DEF  = 5;
  localparam int HZ_MEM_TIMEOUT_DEF = 16;
  localparam int HZ_PERF_W_DEF      = 32;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle seen by hazard_ctrl: register addresses, stage enables, memory req/ack and controls.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W_DEF,
  parameter int PERF_W     = HZ_PERF_W_DEF
);
  logic [REG_ADDR_W-1:0] RA1D, RA2D, RA1E, RA2E;
  logic [REG_ADDR_W-1:0] WA3E, WA3M, WA3W;
  logic                  RegWriteE, RegWriteM, RegWriteW;
  logic                  MemToRegE, BranchTakenE;
  // MemReqM is held by M for the whole access; the access completes in the cycle MemAckM is high.
  logic                  MemReqM, MemAckM;

  logic [1:0]            ForwardAE, ForwardBE;
  logic                  StallF, StallD, StallE, StallM;
  logic                  FlushD, FlushE, FlushW;
  logic                  MemErr;
  logic [PERF_W-1:0]     StallCycles, FlushCount;
  hz_state_e             State;

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemToRegE, BranchTakenE,
    input  MemReqM, MemAckM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemErr, StallCycles, FlushCount, State
  );

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW, MemToRegE, BranchTakenE,
    output MemReqM, MemAckM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemErr, StallCycles, FlushCount, State
  );

endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// Source comparator for one Execute operand; the M stage result wins over W.
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] ra_i,
  input  logic [REG_ADDR_W-1:0] wa_m_i,
  input  logic [REG_ADDR_W-1:0] wa_w_i,
  input  logic                  we_m_i,
  input  logic                  we_w_i,
  output fwd_sel_e              sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (we_m_i && (wa_m_i != '0) && (wa_m_i == ra_i)) begin
      sel_o = FWD_MEM;
    end else if (we_w_i && (wa_w_i != '0) && (wa_w_i == ra_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use/branch handling and a memory-wait FSM with timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = HZ_REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = HZ_MEM_TIMEOUT_DEF,
  parameter int PERF_W      = HZ_PERF_W_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  hazard_ctrl_if.slave  hz
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  fwd_sel_e         fwd_a, fwd_b;

  logic mem_stall, lu_hit, br_hit;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w, mem_err;

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ra_i   (hz.RA1E),
    .wa_m_i (hz.WA3M),
    .wa_w_i (hz.WA3W),
    .we_m_i (hz.RegWriteM),
    .we_w_i (hz.RegWriteW),
    .sel_o  (fwd_a)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ra_i   (hz.RA2E),
    .wa_m_i (hz.WA3M),
    .wa_w_i (hz.WA3W),
    .we_m_i (hz.RegWriteM),
    .we_w_i (hz.RegWriteW),
    .sel_o  (fwd_b)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter saturates at MEM_TIMEOUT; reaching it ends the wait in FAULT.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (hz.MemReqM && !hz.MemAckM) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.MemAckM) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) state_d = FAULT;
        end
      end
      FAULT:   state_d = FAULT;
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    lu_hit    = 1'b0;
    br_hit    = 1'b0;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;
    mem_err   = 1'b0;
    if (!RST) begin
      mem_stall = (state_q == FAULT) ||
                  ((state_q == RUN || state_q == MEM_WAIT) && hz.MemReqM && !hz.MemAckM) ||
                  ((state_q == MEM_WAIT) && !hz.MemAckM);
      lu_hit    = (state_q == RUN) && !mem_stall && hz.MemToRegE && hz.RegWriteE &&
                  (hz.WA3E != '0) && ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
      // A branch stalled in E during a wait resolves in the ack cycle.
      br_hit    = !mem_stall && hz.BranchTakenE && (state_q != FAULT);
      stall_f   = mem_stall || (lu_hit && !br_hit);
      stall_d   = stall_f;
      stall_e   = mem_stall;
      stall_m   = mem_stall;
      flush_d   = br_hit;
      flush_e   = br_hit || lu_hit;
      flush_w   = mem_stall && (state_q != FAULT);
      mem_err   = (state_q == FAULT);
    end
  end

  assign hz.ForwardAE = RST ? 2'b00 : fwd_a;
  assign hz.ForwardBE = RST ? 2'b00 : fwd_b;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.MemErr    = mem_err;
  assign hz.State     = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cyc_q, flush_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f)             stall_cyc_q <= stall_cyc_q + PERF_W'(1);
      if (flush_d || flush_e)  flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign hz.StallCycles = stall_cyc_q;
  assign hz.FlushCount  = flush_cnt_q;
`else
  assign hz.StallCycles = {PERF_W{1'b0}};
  assign hz.FlushCount  = {PERF_W{1'b0}};
`endif

endmodule
